// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch squash, exec/mem waits.
// Optional statistics counters are built when HAZARD_CTRL_STATS_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_TIMEOUT    = 255
`ifdef HAZARD_CTRL_STATS_EN
  ,
  parameter int CNT_WIDTH      = 32
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rt_addr,
  input  logic                      dec_uses_rs,
  input  logic                      dec_uses_rt,
  input  logic                      exec_mem_enable,
  input  logic                      exec_mem_rw,
  input  logic                      exec_wb_reg,
  input  logic [REG_ADDR_WIDTH-1:0] exec_write_addr,
  input  logic                      exec_busy,
  input  logic                      branch_taken,
  input  logic [ADDR_WIDTH-1:0]     branch_target,
  input  logic                      mem_req,
  input  logic                      mem_ack,
  output logic                      pc_write,
  output logic                      redirect_valid,
  output logic [ADDR_WIDTH-1:0]     redirect_target,
  output logic                      stall_f2d,
  output logic                      stall_d2e,
  output logic                      stall_e2m,
  output logic                      stall_m2w,
  output logic                      flush_f2d,
  output logic                      flush_d2e,
  output logic                      flush_e2m,
  output logic                      flush_m2w,
  output logic                      mem_timeout
`ifdef HAZARD_CTRL_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]      stall_cycles,
  output logic [CNT_WIDTH-1:0]      flush_events,
  output logic [CNT_WIDTH-1:0]      loaduse_events
`endif
);

  localparam int WCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TO_VAL = WCNT_W'(MEM_TIMEOUT);

  localparam logic [1:0] S_RUN       = 2'd0;
  localparam logic [1:0] S_EXEC_WAIT = 2'd1;
  localparam logic [1:0] S_MEM_WAIT  = 2'd2;

  // stall/flush bit order: [0]=f2d [1]=d2e [2]=e2m [3]=m2w
  typedef struct packed {
    logic       pc_write;
    logic       redirect;
    logic [3:0] stall;
    logic [3:0] flush;
  } ctrl_t;

  localparam ctrl_t C_MEM  = '{pc_write: 1'b0, redirect: 1'b0, stall: 4'b0111, flush: 4'b1000};
  localparam ctrl_t C_BUSY = '{pc_write: 1'b0, redirect: 1'b0, stall: 4'b0011, flush: 4'b0100};

  logic [1:0]        r_state;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic              r_mem_timeout;

  logic [1:0]        w_nstate;
  logic [WCNT_W-1:0] w_ncnt;
  logic              w_set_to;
  logic              w_eval;
  logic              w_eval_mem;
  logic              w_load_use;
  ctrl_t             w_ctrl;
  ctrl_t             w_out;

  assign w_load_use = exec_mem_enable && !exec_mem_rw && exec_wb_reg &&
                      (exec_write_addr != '0) &&
                      ((dec_uses_rs && (dec_rs_addr == exec_write_addr)) ||
                       (dec_uses_rt && (dec_rt_addr == exec_write_addr)));

  always_comb begin
    w_ctrl     = '0;
    w_nstate   = S_RUN;
    w_ncnt     = '0;
    w_set_to   = 1'b0;
    w_eval     = 1'b0;
    w_eval_mem = 1'b0;
    unique case (r_state)
      S_EXEC_WAIT: begin
        if (exec_busy) begin
          w_ctrl   = C_BUSY;
          w_nstate = S_EXEC_WAIT;
        end else begin
          w_eval     = 1'b1;
          w_eval_mem = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (!mem_ack && (r_wait_cnt != TO_VAL)) begin
          w_ctrl   = C_MEM;
          w_nstate = S_MEM_WAIT;
          w_ncnt   = r_wait_cnt + WCNT_W'(1);
        end else begin
          // a watchdog release re-evaluates the frozen exec instr like a real ack
          w_eval   = 1'b1;
          w_set_to = !mem_ack;
        end
      end
      default: begin
        w_eval     = 1'b1;
        w_eval_mem = 1'b1;
      end
    endcase

    if (w_eval) begin
      if (w_eval_mem && mem_req && !mem_ack) begin
        w_ctrl   = C_MEM;
        w_nstate = S_MEM_WAIT;
        w_ncnt   = WCNT_W'(1);
      end else if (exec_busy) begin
        w_ctrl   = C_BUSY;
        w_nstate = S_EXEC_WAIT;
      end else if (branch_taken) begin
        w_ctrl.pc_write = 1'b1;
        w_ctrl.redirect = 1'b1;
        w_ctrl.flush    = 4'b0011;
      end else if (w_load_use) begin
        w_ctrl.stall = 4'b0001;
        w_ctrl.flush = 4'b0010;
      end else begin
        w_ctrl.pc_write = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_nstate;
      r_wait_cnt    <= w_ncnt;
      r_mem_timeout <= r_mem_timeout | w_set_to;
    end
  end

  // reset forces every control low without waiting for a clock edge
  assign w_out = rst_n ? w_ctrl : '0;

  assign pc_write        = w_out.pc_write;
  assign redirect_valid  = w_out.redirect;
  assign redirect_target = w_out.redirect ? branch_target : '0;
  assign stall_f2d       = w_out.stall[0];
  assign stall_d2e       = w_out.stall[1];
  assign stall_e2m       = w_out.stall[2];
  assign stall_m2w       = w_out.stall[3];
  assign flush_f2d       = w_out.flush[0];
  assign flush_d2e       = w_out.flush[1];
  assign flush_e2m       = w_out.flush[2];
  assign flush_m2w       = w_out.flush[3];
  assign mem_timeout     = r_mem_timeout;

`ifdef HAZARD_CTRL_STATS_EN
  logic [CNT_WIDTH-1:0] r_stall_cycles;
  logic [CNT_WIDTH-1:0] r_flush_events;
  logic [CNT_WIDTH-1:0] r_loaduse_events;
  logic                 w_lu_evt;

  // the load-use bubble is the only response that holds f2d alone
  assign w_lu_evt = (w_ctrl.stall == 4'b0001);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles   <= '0;
      r_flush_events   <= '0;
      r_loaduse_events <= '0;
    end else begin
      if (!w_ctrl.pc_write && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
      if (w_ctrl.redirect && (r_flush_events != '1))
        r_flush_events <= r_flush_events + CNT_WIDTH'(1);
      if (w_lu_evt && (r_loaduse_events != '1))
        r_loaduse_events <= r_loaduse_events + CNT_WIDTH'(1);
    end
  end

  assign stall_cycles   = r_stall_cycles;
  assign flush_events   = r_flush_events;
  assign loaduse_events = r_loaduse_events;
`else
  // statistics counters not built
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;
  localparam int RW = 5;
  localparam int AW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [RW-1:0] dec_rs_addr = '0, dec_rt_addr = '0, exec_write_addr = '0;
  logic          dec_uses_rs = 0, dec_uses_rt = 0;
  logic          exec_mem_enable = 0, exec_mem_rw = 0, exec_wb_reg = 0, exec_busy = 0;
  logic          branch_taken = 0, mem_req = 0, mem_ack = 0;
  logic [AW-1:0] branch_target = '0;
  logic          pc_write, redirect_valid;
  logic [AW-1:0] redirect_target;
  logic          stall_f2d, stall_d2e, stall_e2m, stall_m2w;
  logic          flush_f2d, flush_d2e, flush_e2m, flush_m2w;
  logic          mem_timeout;
`ifdef HAZARD_CTRL_STATS_EN
  logic [31:0]   stall_cycles, flush_events, loaduse_events;
  int            m_stall_n = 0, m_flush_n = 0, m_lu_n = 0;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(RW), .ADDR_WIDTH(AW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_rs_addr(dec_rs_addr), .dec_rt_addr(dec_rt_addr),
    .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt),
    .exec_mem_enable(exec_mem_enable), .exec_mem_rw(exec_mem_rw),
    .exec_wb_reg(exec_wb_reg), .exec_write_addr(exec_write_addr),
    .exec_busy(exec_busy), .branch_taken(branch_taken), .branch_target(branch_target),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_write(pc_write), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .stall_f2d(stall_f2d), .stall_d2e(stall_d2e), .stall_e2m(stall_e2m), .stall_m2w(stall_m2w),
    .flush_f2d(flush_f2d), .flush_d2e(flush_d2e), .flush_e2m(flush_e2m), .flush_m2w(flush_m2w),
    .mem_timeout(mem_timeout)
`ifdef HAZARD_CTRL_STATS_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events), .loaduse_events(loaduse_events)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  // model state: stalled-cycle count of a pending memory access, exec-hold flag, sticky error
  bit m_exec = 0;
  int m_mcnt = 0;
  bit m_to = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  // sample at negedge against the model, then advance to just after the next posedge
  task automatic tick(input string tag);
    bit pcw, rv, sf, sd, se, sm, ff, fd, fe, fm, eto, lu, allow_mem;
    logic [10:0] e, o;
    @(negedge clk);
    {pcw, rv, sf, sd, se, sm, ff, fd, fe, fm, eto} = '0;
    lu = exec_mem_enable && !exec_mem_rw && exec_wb_reg && exec_write_addr != 0 &&
         ((dec_uses_rs && dec_rs_addr == exec_write_addr) ||
          (dec_uses_rt && dec_rt_addr == exec_write_addr));
`ifdef HAZARD_CTRL_STATS_EN
    chk({tag, "/st_stall"}, stall_cycles, m_stall_n);
    chk({tag, "/st_flush"}, flush_events, m_flush_n);
    chk({tag, "/st_lu"}, loaduse_events, m_lu_n);
`endif
    if (!rst_n) begin
      m_exec = 0; m_mcnt = 0; m_to = 0;
`ifdef HAZARD_CTRL_STATS_EN
      m_stall_n = 0; m_flush_n = 0; m_lu_n = 0;
`endif
    end else begin
      eto = m_to;
      if (m_mcnt > 0 && !mem_ack && m_mcnt < TO) begin
        sf = 1; sd = 1; se = 1; fm = 1;
        m_mcnt++;
      end else if (m_mcnt == 0 && m_exec && exec_busy) begin
        sf = 1; sd = 1; fe = 1;
      end else begin
        allow_mem = (m_mcnt == 0);
        if (m_mcnt > 0 && !mem_ack) m_to = 1;
        m_mcnt = 0;
        if (allow_mem && mem_req && !mem_ack) begin
          sf = 1; sd = 1; se = 1; fm = 1; m_mcnt = 1; m_exec = 0;
        end else if (exec_busy) begin
          sf = 1; sd = 1; fe = 1; m_exec = 1;
        end else begin
          m_exec = 0;
          if (branch_taken) begin
            pcw = 1; rv = 1; ff = 1; fd = 1;
          end else if (lu) begin
            sf = 1; fd = 1;
          end else pcw = 1;
        end
      end
`ifdef HAZARD_CTRL_STATS_EN
      if (!pcw) m_stall_n++;
      if (rv) m_flush_n++;
      if (!rv && lu && sf && !sd) m_lu_n++;
`endif
    end
    e = {pcw, rv, sf, sd, se, sm, ff, fd, fe, fm, eto};
    o = {pc_write, redirect_valid, stall_f2d, stall_d2e, stall_e2m, stall_m2w,
         flush_f2d, flush_d2e, flush_e2m, flush_m2w, mem_timeout};
    chk({tag, "/ctl"}, o, e);
    if (rv) chk({tag, "/tgt"}, redirect_target, branch_target);
    @(posedge clk); #1;
  endtask

  task automatic clear_in();
    {dec_uses_rs, dec_uses_rt, exec_mem_enable, exec_mem_rw, exec_wb_reg} = '0;
    {exec_busy, branch_taken, mem_req, mem_ack} = '0;
    dec_rs_addr = '0; dec_rt_addr = '0; exec_write_addr = '0; branch_target = '0;
  endtask

  initial begin
    clear_in();
    tick("rst0");
    tick("rst1");
    rst_n = 1;
    tick("idle");
    // load-use on rs=3, then the same pattern with r0 which never hazards
    exec_mem_enable = 1; exec_wb_reg = 1; exec_write_addr = 5'd3;
    dec_uses_rs = 1; dec_rs_addr = 5'd3;
    tick("lu");
    clear_in();
    tick("lu_clr");
    exec_mem_enable = 1; exec_wb_reg = 1; exec_write_addr = 5'd0;
    dec_uses_rs = 1; dec_rs_addr = 5'd0;
    tick("lu_r0");
    clear_in();
    branch_taken = 1; branch_target = 32'h40;
    tick("br");
    clear_in();
    mem_req = 1;
    repeat (4) tick("mem_wait");
    mem_ack = 1;
    tick("mem_ack");
    clear_in();
    tick("mem_post");
    exec_busy = 1; branch_taken = 1; branch_target = 32'h80;
    repeat (3) tick("busy_br");
    exec_busy = 0;
    tick("busy_rel");
    clear_in();
    mem_req = 1;
    repeat (TO) tick("to_wait");
    tick("to_rel");
    chk("to_set", mem_timeout, 1'b1);
    clear_in();
    repeat (3) tick("to_idle");
    chk("to_sticky", mem_timeout, 1'b1);
    mem_req = 1;
    repeat (2) tick("mid_wait");
    rst_n = 0;
    tick("rst_mid");
    chk("rst_to_clr", mem_timeout, 1'b0);
    rst_n = 1;
    clear_in();
    tick("post_rst");

    for (int i = 0; i < 3000; i++) begin
      rst_n           = ($urandom_range(0, 199) != 0);
      dec_rs_addr     = RW'($urandom_range(0, 3));
      dec_rt_addr     = RW'($urandom_range(0, 3));
      exec_write_addr = RW'($urandom_range(0, 3));
      dec_uses_rs     = $urandom_range(0, 1) == 1;
      dec_uses_rt     = $urandom_range(0, 1) == 1;
      exec_mem_enable = $urandom_range(0, 1) == 1;
      exec_mem_rw     = $urandom_range(0, 3) == 0;
      exec_wb_reg     = $urandom_range(0, 3) != 0;
      exec_busy       = $urandom_range(0, 3) == 0;
      branch_taken    = $urandom_range(0, 3) == 0;
      branch_target   = $urandom;
      mem_req         = $urandom_range(0, 3) == 0;
      mem_ack         = $urandom_range(0, 9) < 3;
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives the stall/flush inputs of the fetch2dec, dec2exec, exec2mem and mem2wb pipeline registers, plus the PC write enable and branch redirect.
- Sequences load-use bubbles, taken-branch squashes, multi-cycle exec waits and memory-access waits with a small FSM and a memory watchdog.

Parameters:
- REG_ADDR_WIDTH, 5, virtual register address width
- ADDR_WIDTH, 32, PC width
- MEM_TIMEOUT, 255, max MEM_WAIT cycles before forced release
- CNT_WIDTH, 32, statistics counter width (optional feature only)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- dec_rs_addr  in  REG_ADDR_WIDTH  decode-stage rs
- dec_rt_addr  in  REG_ADDR_WIDTH  decode-stage rt
- dec_uses_rs  in  1  decode instr reads rs
- dec_uses_rt  in  1  decode instr reads rt
- exec_mem_enable  in  1  exec instr accesses memory
- exec_mem_rw  in  1  0=read, 1=write
- exec_wb_reg  in  1  exec instr writes a register
- exec_write_addr  in  REG_ADDR_WIDTH  exec destination
- exec_busy  in  1  multi-cycle ALU op not finished
- branch_taken  in  1  exec branch resolved taken
- branch_target  in  ADDR_WIDTH  resolved target
- mem_req  in  1  mem stage issuing access
- mem_ack  in  1  memory access complete
- pc_write  out  1  PC may update
- redirect_valid  out  1  load PC from redirect_target
- redirect_target  out  ADDR_WIDTH  redirect PC
- stall_f2d, stall_d2e, stall_e2m, stall_m2w  out  1 each  register hold
- flush_f2d, flush_d2e, flush_e2m, flush_m2w  out  1 each  register bubble (effective only when the matching stall is low)
- mem_timeout  out  1  sticky watchdog error

Behaviour:
- Reset: clk is the sole clock; rst_n is asynchronous active-low. While rst_n=0: state=RUN, wait counter=0, mem_timeout=0; all stall/flush/redirect outputs forced 0; pc_write=0.
- All stall/flush/redirect outputs are combinational from state and inputs: zero-latency, valid in the cycle they apply.
- FSM states: RUN, EXEC_WAIT, MEM_WAIT.
- RUN priority (highest first):
  1. mem_req&&!mem_ack: stall_f2d/d2e/e2m=1, pc_write=0, flush_m2w=1; next MEM_WAIT, counter=1.
  2. exec_busy: stall_f2d/d2e=1, pc_write=0, flush_e2m=1; next EXEC_WAIT.
  3. branch_taken: redirect_valid=1, redirect_target=branch_target, pc_write=1, flush_f2d=1, flush_d2e=1.
  4. Load-use: exec_mem_enable&&!exec_mem_rw&&exec_wb_reg&&exec_write_addr!=0&&((dec_uses_rs&&dec_rs_addr==exec_write_addr)||(dec_uses_rt&&dec_rt_addr==exec_write_addr)). Response: stall_f2d=1, pc_write=0, flush_d2e=1 (one bubble).
  5. Otherwise: pc_write=1, all stall/flush=0.
- EXEC_WAIT:
  - While exec_busy: same outputs as RUN case 2.
  - When exec_busy=0: outputs and next state evaluated exactly as RUN (returns to RUN, or MEM_WAIT if that case fires).
- MEM_WAIT:
  - While !mem_ack: same outputs as RUN case 1; counter increments.
  - mem_ack=1: release. Outputs as RUN cases 2-5; next RUN (or EXEC_WAIT); counter=0.
  - Counter reaching MEM_TIMEOUT with no ack: set mem_timeout (sticky until reset), release as if acked.
- Branch or load-use seen while stalled is not acted on; the exec instr is frozen and re-evaluated on release.
- rst_n asserted mid-wait aborts immediately to RUN.

Optional Feature:
- Macro HAZARD_CTRL_STATS_EN.
- Defined: adds outputs stall_cycles, flush_events, loaduse_events (CNT_WIDTH each); reset to 0; saturate at all-ones.
  - stall_cycles increments on any cycle with pc_write=0 outside reset.
  - flush_events increments per taken-branch redirect.
  - loaduse_events increments per load-use bubble.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Load r3 in exec, decode uses rs=3 -> 1 cycle stall_f2d=1, flush_d2e=1, pc_write=0; next cycle all clear. Repeat with rs=0 -> no stall.
- branch_taken=1, target=0x40 in RUN -> same cycle redirect_valid=1, redirect_target=0x40, flush_f2d=flush_d2e=1.
- mem_req=1, mem_ack arriving 4 cycles later -> stall_f2d/d2e/e2m=1 and flush_m2w=1 for 4 cycles, released in the ack cycle, state RUN.
- exec_busy high 3 cycles while branch_taken=1 -> 3 cycles flush_e2m=1 with no redirect, then redirect to target in release cycle.
- mem_req with no ack, MEM_TIMEOUT=8 -> release after 8 cycles, mem_timeout=1 and stays 1 until rst_n pulse; rst_n low mid-wait -> all outputs 0 immediately.
- HAZARD_CTRL_STATS_EN: 2 load-use bubbles + 1 branch + 4-cycle mem wait -> loaduse_events=2, flush_events=1, stall_cycles=6.
